npc_unit: RTL

- Parametrised next-PC generator with the PC register built in. It replaces the purely combinational next-PC block used by the multicycle datapath.
- Computes and registers the next PC for sequential, branch, jump, jump-and-link, jump-register and exception-return flow.
- Adds exception vectoring with an EPC register.
- Adds a small return-address stack (RAS). The RAS detects jr $ra targets that do not match the stack, for debug and future fetch prediction.

---
 rtl/npc_unit_pkg.sv | 18 +
 rtl/npc_ras.sv | 85 ++++++++
 rtl/npc_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/npc_unit_pkg.sv
// Shared definitions for the next-PC unit: flow-control opcodes and
// default reset / exception-vector addresses.
package npc_unit_pkg;

  // Next-PC selection codes driven by the controller (codes 110/111 act as SEQ)
  typedef enum logic [2:0] {
    NPC_SEQ  = 3'b000,
    NPC_BR   = 3'b001,
    NPC_J    = 3'b010,
    NPC_JAL  = 3'b011,
    NPC_JR   = 3'b100,
    NPC_ERET = 3'b101
  } npc_op_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NPC_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack. Pushes overwrite the oldest entry when
// full (flagged by a sticky overflow bit); pops compare the jr $ra target
// against the popped entry and raise a one-cycle miss pulse on mismatch.
module npc_ras #(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  input  logic [AW-1:0] pop_target,
  output logic [AW-1:0] ras_top,
  output logic          ras_empty,
  output logic          ras_ovf,
  output logic          ras_miss
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  logic [AW-1:0] stack_r [RAS_DEPTH];
  logic [PW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_r;
  logic          miss_r;
  logic [PW-1:0] top_idx_s;
  logic          empty_s;
  logic          full_s;
  logic [AW-1:0] top_s;

  // Top-of-stack index, occupancy flags and the visible top entry
  always_comb begin
    top_idx_s = ptr_r - PTR_ONE;
    empty_s   = (cnt_r == '0);
    full_s    = (cnt_r == CNT_FULL);
    if (empty_s) begin
      top_s = '0;
    end else begin
      top_s = stack_r[top_idx_s];
    end
  end

  // Stack storage, pointer/count, sticky overflow and registered miss pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_r[i] <= '0;
      end
      ptr_r  <= '0;
      cnt_r  <= '0;
      ovf_r  <= 1'b0;
      miss_r <= 1'b0;
    end else if (push) begin
      stack_r[ptr_r] <= push_data;
      ptr_r          <= ptr_r + PTR_ONE;
      miss_r         <= 1'b0;
      if (full_s) begin
        ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if (pop) begin
      if (empty_s) begin
        miss_r <= 1'b1;
      end else begin
        ptr_r  <= top_idx_s;
        cnt_r  <= cnt_r - CNT_ONE;
        miss_r <= (stack_r[top_idx_s] != pop_target);
      end
    end else begin
      miss_r <= 1'b0;
    end
  end

  assign ras_top   = top_s;
  assign ras_empty = empty_s;
  assign ras_ovf   = ovf_r;
  assign ras_miss  = miss_r;

endmodule

// File: rtl/npc_unit.sv
// Next-PC generator with integrated PC and EPC registers, exception
// vectoring and a return-address stack that checks jr $ra targets.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = AW'(NPC_RESET_PC),
  parameter logic [AW-1:0] EXC_VEC   = AW'(NPC_EXC_VEC),
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_we,
  input  logic [2:0]    npc_op,
  input  logic          br_taken,
  input  logic [15:0]   imm16,
  input  logic [25:0]   imm26,
  input  logic [AW-1:0] jr_target,
  input  logic          jr_is_ra,
  input  logic          exc_req,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic [AW-1:0] pc_plus4,
  output logic [AW-1:0] epc,
  output logic [AW-1:0] ras_top,
  output logic          ras_empty,
  output logic          ras_ovf,
  output logic          ras_miss
);

  localparam logic [AW-1:0] FOUR = AW'(4);

  logic [AW-1:0] pc_r;
  logic [AW-1:0] epc_r;
  logic [AW-1:0] pc_plus4_s;
  logic [AW-1:0] br_off_s;
  logic [AW-1:0] jmp_s;
  logic [AW-1:0] jr_s;
  logic [AW-1:0] npc_s;
  logic          adv_s;
  logic          push_s;
  logic          pop_s;

  // Candidate targets and the next-PC mux for the presented opcode
  always_comb begin
    pc_plus4_s      = pc_r + FOUR;
    br_off_s        = {{(AW-18){imm16[15]}}, imm16, 2'b00};
    jmp_s           = pc_plus4_s;
    jmp_s[27:0]     = {imm26, 2'b00};
    jr_s            = {jr_target[AW-1:2], 2'b00};
    case (npc_op)
      NPC_SEQ: npc_s = pc_plus4_s;
      NPC_BR: begin
        if (br_taken) begin
          npc_s = pc_plus4_s + br_off_s;
        end else begin
          npc_s = pc_plus4_s;
        end
      end
      NPC_J:    npc_s = jmp_s;
      NPC_JAL:  npc_s = jmp_s;
      NPC_JR:   npc_s = jr_s;
      NPC_ERET: npc_s = epc_r;
      default:  npc_s = pc_plus4_s;
    endcase
  end

  // RAS strobes: only a real, non-excepted PC advance may push or pop
  always_comb begin
    adv_s  = pc_we & ~exc_req;
    push_s = adv_s & (npc_op == NPC_JAL);
    pop_s  = adv_s & (npc_op == NPC_JR) & jr_is_ra;
  end

  // PC and EPC registers with priority reset > exception > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r  <= RESET_PC;
      epc_r <= '0;
    end else if (exc_req) begin
      epc_r <= pc_r;
      pc_r  <= EXC_VEC;
    end else if (pc_we) begin
      pc_r <= npc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  npc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .push_data  (pc_plus4_s),
    .pop_target (jr_s),
    .ras_top    (ras_top),
    .ras_empty  (ras_empty),
    .ras_ovf    (ras_ovf),
    .ras_miss   (ras_miss)
  );

  assign pc       = pc_r;
  assign npc      = npc_s;
  assign pc_plus4 = pc_plus4_s;
  assign epc      = epc_r;

endmodule
